// File: rtl/hex_disp_scan_4dig.sv
// Four-digit hex display scanner: multiplexes a double-buffered 16-bit value onto a
// shared nibble bus with active-low anodes. Optional macro: LEADING_ZERO_BLANK_EN.
module hex_disp_scan_4dig #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [15:0] din,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        frame_sync,
  output logic        pend
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   disp;

  logic          slot_end;
  logic          wrap;
  logic          blank;
  logic [3:0]    suppress;
  logic [3:0]    nib_next;
  logic [3:0]    an_next;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == 2'd3);

  always_comb begin
    nib_next = 4'h0;
    case (idx)
      2'd0:    nib_next = disp[3:0];
      2'd1:    nib_next = disp[7:4];
      2'd2:    nib_next = disp[11:8];
      default: nib_next = disp[15:12];
    endcase
  end

  // Leading-zero suppression looks only at the committed value, never at shadow.
  always_comb begin
    suppress = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    suppress[1] = (disp[15:4]  == 12'h000);
    suppress[2] = (disp[15:8]  == 8'h00);
    suppress[3] = (disp[15:12] == 4'h0);
`endif
  end

  always_comb begin
    blank   = (32'(cnt) < BLANK_CYC);
    an_next = 4'b1111;
    if (!blank && !suppress[idx]) an_next = ~(4'b0001 << idx);
  end

  // Load handshake: ld is accepted on every edge (no ready); the last ld before a
  // wrap wins, and an ld on the wrap edge lands after the commit of the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      disp       <= 16'h0000;
      pend       <= 1'b0;
      nib        <= 4'h0;
      an         <= 4'b1111;
      frame_sync <= 1'b0;
    end else begin
      nib        <= nib_next;
      an         <= an_next;
      frame_sync <= wrap;
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (wrap && pend) begin
        disp <= shadow;
        pend <= 1'b0;
      end
      if (ld) begin
        shadow <= din;
        pend   <= 1'b1;
      end
    end
  end

endmodule
